// File: rtl/tdm_mux_8to1.sv
// rtl/tdm_mux_8to1.sv - 8-to-1 time-division multiplexer with select code, frame markers and ready stall (optional parity slot: TDM_PARITY_EN)
module tdm_mux_8to1 #(
    parameter int DWELL = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] I,
    input  logic       ready,
    output logic       Y,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic       valid,
    output logic       frame_start,
    output logic       frame_done,
    output logic       busy,
    output logic       par_slot
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DLAST = DW'(DWELL - 1);

`ifdef TDM_PARITY_EN
    localparam logic [3:0] LAST_CH = 4'd8;
`else
    localparam logic [3:0] LAST_CH = 4'd7;
`endif

    typedef enum logic {IDLE, SCAN} state_t;

    state_t        state, state_n;
    logic [3:0]    ch, ch_n;
    logic [DW-1:0] dwell, dwell_n;
    logic [7:0]    shadow, shadow_n;
    logic          done_n;
    logic          scan_n;
    logic          y_n;
    logic [2:0]    sel_n;
    logic          fs_n;
    logic          par_n;

    // Next-state and next-output logic; outputs are derived from the next state so they can be registered
    always_comb begin
        state_n  = state;
        ch_n     = ch;
        dwell_n  = dwell;
        shadow_n = shadow;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    shadow_n = I;
                    ch_n     = 4'd0;
                    dwell_n  = '0;
                    state_n  = SCAN;
                end
            end
            SCAN: begin
                if (ready) begin
                    if (dwell != DLAST) begin
                        dwell_n = dwell + 1'b1;
                    end else begin
                        dwell_n = '0;
                        if (ch == LAST_CH) begin
                            done_n = 1'b1;
                            ch_n   = 4'd0;
                            if (en) begin
                                shadow_n = I;
                            end else begin
                                state_n = IDLE;
                            end
                        end else begin
                            ch_n = ch + 4'd1;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        scan_n = (state_n == SCAN);
        y_n    = 1'b0;
        sel_n  = 3'd0;
        if (scan_n) begin
            if (ch_n == 4'd8) begin
                y_n = ^shadow_n;
            end else begin
                y_n   = shadow_n[ch_n[2:0]];
                sel_n = ch_n[2:0];
            end
        end
        fs_n = scan_n && (ch_n == 4'd0) && (dwell_n == '0);
`ifdef TDM_PARITY_EN
        par_n = scan_n && (ch_n == 4'd8);
`else
        par_n = 1'b0;
`endif
    end

    // State and registered-output update; reset wins over everything and aborts a frame silently
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ch          <= 4'd0;
            dwell       <= '0;
            shadow      <= 8'h00;
            Y           <= 1'b0;
            s0          <= 1'b0;
            s1          <= 1'b0;
            s2          <= 1'b0;
            valid       <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
            par_slot    <= 1'b0;
        end else begin
            state       <= state_n;
            ch          <= ch_n;
            dwell       <= dwell_n;
            shadow      <= shadow_n;
            Y           <= y_n;
            s0          <= sel_n[0];
            s1          <= sel_n[1];
            s2          <= sel_n[2];
            valid       <= scan_n;
            frame_start <= fs_n;
            frame_done  <= done_n;
            busy        <= scan_n;
            par_slot    <= par_n;
        end
    end

endmodule

// File: tb/tb_tdm_mux_8to1.sv
// tb/tb_tdm_mux_8to1.sv - bench for tdm_mux_8to1 (DWELL=1 and DWELL=3 side by side against a beat-index model)
module tb_tdm_mux_8to1;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       ready;
    logic [7:0] I;
    logic [1:0] y, s0, s1, s2, valid, fs, fd, busy, par;

    always #5 clk = ~clk;

    tdm_mux_8to1 #(.DWELL(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .I(I), .ready(ready),
        .Y(y[0]), .s0(s0[0]), .s1(s1[0]), .s2(s2[0]), .valid(valid[0]),
        .frame_start(fs[0]), .frame_done(fd[0]), .busy(busy[0]), .par_slot(par[0])
    );

    tdm_mux_8to1 #(.DWELL(3)) dut3 (
        .clk(clk), .rst(rst), .en(en), .I(I), .ready(ready),
        .Y(y[1]), .s0(s0[1]), .s1(s1[1]), .s2(s2[1]), .valid(valid[1]),
        .frame_start(fs[1]), .frame_done(fd[1]), .busy(busy[1]), .par_slot(par[1])
    );

`ifdef TDM_PARITY_EN
    localparam int NS = 9;
`else
    localparam int NS = 8;
`endif

    int checks = 0;
    int errors = 0;

    // Model: a frame is a run of NS*D beats; beat index b gives slot b/D
    bit         m_act  [2];
    int         m_b    [2];
    logic [7:0] m_snap [2];
    bit         m_done [2];
    int         beats  [2];
    bit         rec = 1'b0;
    logic       rec_q [$];

    function automatic int dw(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic step();
        for (int k = 0; k < 2; k++)
            if (valid[k] && ready && !rst) beats[k]++;
        if (rec && valid[0] && ready) rec_q.push_back(y[0]);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            int last;
            last = NS * dw(k) - 1;
            if (rst) begin
                m_act[k] = 0; m_b[k] = 0; m_snap[k] = 8'h00; m_done[k] = 0;
            end else if (!m_act[k]) begin
                m_done[k] = 0;
                if (en) begin
                    m_act[k] = 1; m_b[k] = 0; m_snap[k] = I;
                end
            end else begin
                m_done[k] = 0;
                if (ready) begin
                    if (m_b[k] == last) begin
                        m_done[k] = 1;
                        m_b[k] = 0;
                        if (en) m_snap[k] = I;
                        else    m_act[k] = 0;
                    end else begin
                        m_b[k]++;
                    end
                end
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            int         slot;
            logic       ey;
            logic [2:0] esel;
            logic [8:0] exp_v, obs_v;
            slot = m_b[k] / dw(k);
            ey   = 1'b0;
            esel = 3'd0;
            if (m_act[k]) begin
                if (slot == 8) ey = ^m_snap[k];
                else begin
                    ey   = m_snap[k][slot];
                    esel = 3'(slot);
                end
            end
            exp_v = {ey, esel, m_act[k], m_act[k] && m_b[k] == 0, m_done[k], m_act[k], m_act[k] && slot == 8};
            obs_v = {y[k], s2[k], s1[k], s0[k], valid[k], fs[k], fd[k], busy[k], par[k]};
            checks++;
            assert (obs_v === exp_v) else begin
                errors++;
                $error("FAIL dut%0d_outputs {Y,s2,s1,s0,valid,fs,fd,busy,par} observed=%b expected=%b t=%0t", k, obs_v, exp_v, $time);
            end
        end
    endtask

    initial begin
        logic [7:0] a5;
        int n;
        a5 = 8'hA5;
        beats[0] = 0; beats[1] = 0;

        // Reset state
        rst = 1; en = 0; ready = 1; I = 8'h00;
        step(); step();
        rst = 0;
        step();

        // Single frame of 8'hA5; I changes after the request and must be ignored
        I = 8'hA5; en = 1; rec = 1;
        step();
        en = 0; I = 8'h00;
        repeat (30) step();
        rec = 0;
        checks++;
        assert (rec_q.size() == NS) else begin
            errors++;
            $error("FAIL a5_beat_count observed=%0d expected=%0d", rec_q.size(), NS);
        end
        for (int i = 0; i < NS && i < rec_q.size(); i++) begin
            logic eb;
            eb = (i == 8) ? ^a5 : a5[i];
            checks++;
            assert (rec_q[i] === eb) else begin
                errors++;
                $error("FAIL a5_beat%0d observed=%b expected=%b", i, rec_q[i], eb);
            end
        end

        // Stall 4 cycles while the DWELL=1 instance sits on ch 3
        beats[0] = 0;
        I = 8'h3C; en = 1;
        step();
        en = 0;
        n = 0;
        while (!(m_act[0] && m_b[0] == 3) && n < 20) begin
            step();
            n++;
        end
        checks++;
        assert (n < 20) else begin
            errors++;
            $error("FAIL reach_ch3 observed=%0d expected=<20", n);
        end
        ready = 0;
        repeat (4) step();
        ready = 1;
        repeat (30) step();
        checks++;
        assert (beats[0] == NS) else begin
            errors++;
            $error("FAIL stall_beats observed=%0d expected=%0d", beats[0], NS);
        end

        // Back-to-back frames: en held, new data presented at the end edge
        I = 8'h0F; en = 1;
        step();
        I = 8'hF0;
        repeat (16) step();
        en = 0;
        repeat (60) step();

        // Pattern 8'h81 (DWELL=3 instance gives 24 beats)
        I = 8'h81; en = 1;
        step();
        en = 0;
        repeat (30) step();

        // Reset in the middle of a frame at ch 5, then restart
        I = 8'hFF; en = 1;
        step();
        en = 0;
        n = 0;
        while (!(m_act[0] && m_b[0] == 5) && n < 20) begin
            step();
            n++;
        end
        rst = 1;
        step();
        rst = 0;
        step();
        I = 8'h07; en = 1;
        step();
        en = 0;
        repeat (30) step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            en    = ($urandom_range(0, 3) == 0);
            ready = ($urandom_range(0, 3) != 0);
            I     = 8'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
